// File: rtl/basic_axis_ctrl_pkg.sv
// Shared definitions for the multi-channel ap_ctrl_chain sequencer.
//   ModeMaskLsb  : bit position of the channel enable mask within the mode register
//   MaxChannels  : largest supported channel count
//   ctrl_state_e : top-level sequencer states
package basic_axis_ctrl_pkg;

    localparam int unsigned ModeMaskLsb = 0;
    localparam int unsigned MaxChannels = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/basic_axis_done_tracker.sv
// Sticky per-channel completion tracker for one run.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear the sticky done vector (run start)
//   upd_i         : accumulate this cycle's masked done pulses (run in progress)
//   mask_i        : channels enabled for the current run
//   ch_done_i     : raw per-channel done pulses
//   done_next_o   : done vector including this cycle's pulses
//   all_done_o    : every enabled channel has completed (including this cycle)
//   not_done_o    : enabled channels still outstanding after this cycle
module basic_axis_done_tracker #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         upd_i,
    input  logic [N-1:0] mask_i,
    input  logic [N-1:0] ch_done_i,
    output logic [N-1:0] done_next_o,
    output logic         all_done_o,
    output logic [N-1:0] not_done_o
);

    logic [N-1:0] done_q;
    logic [N-1:0] done_d;

    // Pulses from disabled channels never reach the sticky register.
    assign done_next_o = done_q | (ch_done_i & mask_i);
    assign all_done_o  = (done_next_o == mask_i);
    assign not_done_o  = mask_i & ~done_next_o;

    always_comb begin
        done_d = done_q;
        if (clr_i) begin
            done_d = '0;
        end else if (upd_i) begin
            done_d = done_next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/basic_axis_ctrl_chain.sv
// Kernel-level control sequencer for C_NUM_CHANNELS engines with ap_ctrl_chain handshake.
//   ap_clk, ap_rst_n  : kernel clock, asynchronous active-low reset
//   ap_start          : host start level, accepted only while idle
//   ap_continue       : host acknowledge of ap_done (chain mode only)
//   ap_idle/ready/done: block-level handshake outputs
//   mode              : low C_NUM_CHANNELS bits select the channels for the run
//   timeout_cycles    : run timeout in cycles, 0 disables
//   ch_start/ch_abort : per-channel single-cycle start / abort pulses
//   ch_done           : per-channel done pulses
//   status_*          : outcome of the last run; run_cycles counts the last/current run
module basic_axis_ctrl_chain
    import basic_axis_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM_CHANNELS = 4,
    parameter int unsigned C_CHAIN_MODE   = 1,
    parameter int unsigned C_CNT_WIDTH    = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ap_start,
    input  logic                      ap_continue,
    output logic                      ap_idle,
    output logic                      ap_ready,
    output logic                      ap_done,
    input  logic [31:0]               mode,
    input  logic [C_CNT_WIDTH-1:0]    timeout_cycles,
    output logic [C_NUM_CHANNELS-1:0] ch_start,
    output logic [C_NUM_CHANNELS-1:0] ch_abort,
    input  logic [C_NUM_CHANNELS-1:0] ch_done,
    output logic                      status_timeout,
    output logic [C_NUM_CHANNELS-1:0] status_done_mask,
    output logic [C_CNT_WIDTH-1:0]    run_cycles
);

    localparam logic [C_CNT_WIDTH:0] IncOne = (C_CNT_WIDTH + 1)'(1);

    if (C_NUM_CHANNELS < 1 || C_NUM_CHANNELS > MaxChannels) begin : g_bad_channels
        $error("C_NUM_CHANNELS out of range");
    end

    ctrl_state_e               state_q, state_d;
    logic [C_NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [C_NUM_CHANNELS-1:0] ch_start_q, ch_start_d;
    logic [C_NUM_CHANNELS-1:0] ch_abort_q, ch_abort_d;
    logic [C_NUM_CHANNELS-1:0] status_done_mask_q, status_done_mask_d;
    logic [C_CNT_WIDTH-1:0]    run_cycles_q, run_cycles_d;
    logic                      ap_idle_q, ap_idle_d;
    logic                      ap_ready_q, ap_ready_d;
    logic                      ap_done_q, ap_done_d;
    logic                      status_timeout_q, status_timeout_d;

    logic [C_NUM_CHANNELS-1:0] mode_mask;
    logic                      unused_mode;
    logic                      done_clr;
    logic                      done_upd;
    logic [C_NUM_CHANNELS-1:0] done_next;
    logic                      all_done;
    logic [C_NUM_CHANNELS-1:0] not_done;
    logic [C_CNT_WIDTH:0]      run_cycles_inc;
    logic                      timeout_hit;

    assign mode_mask   = mode[ModeMaskLsb +: C_NUM_CHANNELS];
    assign unused_mode = ^mode;

    // One extra bit so the timeout compare never matches on counter wrap.
    assign run_cycles_inc = {1'b0, run_cycles_q} + IncOne;
    assign timeout_hit    = (timeout_cycles != '0) &&
                            (run_cycles_inc == {1'b0, timeout_cycles});

    basic_axis_done_tracker #(
        .N (C_NUM_CHANNELS)
    ) u_done_tracker (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .clr_i       (done_clr),
        .upd_i       (done_upd),
        .mask_i      (mask_q),
        .ch_done_i   (ch_done),
        .done_next_o (done_next),
        .all_done_o  (all_done),
        .not_done_o  (not_done)
    );

    always_comb begin
        state_d            = state_q;
        mask_d             = mask_q;
        ch_start_d         = '0;
        ch_abort_d         = '0;
        ap_ready_d         = 1'b0;
        ap_idle_d          = ap_idle_q;
        ap_done_d          = ap_done_q;
        status_timeout_d   = status_timeout_q;
        status_done_mask_d = status_done_mask_q;
        run_cycles_d       = run_cycles_q;
        done_clr           = 1'b0;
        done_upd           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    state_d            = StRun;
                    mask_d             = mode_mask;
                    done_clr           = 1'b1;
                    run_cycles_d       = '0;
                    status_timeout_d   = 1'b0;
                    status_done_mask_d = '0;
                    ch_start_d         = mode_mask;
                    ap_ready_d         = 1'b1;
                    ap_idle_d          = 1'b0;
                end
            end
            StRun: begin
                done_upd     = 1'b1;
                run_cycles_d = (run_cycles_q == '1) ? run_cycles_q
                                                    : run_cycles_inc[C_CNT_WIDTH-1:0];
                // Completion takes priority over a coincident timeout.
                if (all_done) begin
                    state_d            = StDone;
                    ap_done_d          = 1'b1;
                    status_done_mask_d = done_next;
                end else if (timeout_hit) begin
                    state_d            = StDone;
                    ap_done_d          = 1'b1;
                    status_done_mask_d = done_next;
                    status_timeout_d   = 1'b1;
                    ch_abort_d         = not_done;
                end
            end
            StDone: begin
                if (C_CHAIN_MODE == 0 || ap_continue) begin
                    state_d   = StIdle;
                    ap_done_d = 1'b0;
                    ap_idle_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q            <= StIdle;
            mask_q             <= '0;
            ch_start_q         <= '0;
            ch_abort_q         <= '0;
            ap_idle_q          <= 1'b1;
            ap_ready_q         <= 1'b0;
            ap_done_q          <= 1'b0;
            status_timeout_q   <= 1'b0;
            status_done_mask_q <= '0;
            run_cycles_q       <= '0;
        end else begin
            state_q            <= state_d;
            mask_q             <= mask_d;
            ch_start_q         <= ch_start_d;
            ch_abort_q         <= ch_abort_d;
            ap_idle_q          <= ap_idle_d;
            ap_ready_q         <= ap_ready_d;
            ap_done_q          <= ap_done_d;
            status_timeout_q   <= status_timeout_d;
            status_done_mask_q <= status_done_mask_d;
            run_cycles_q       <= run_cycles_d;
        end
    end

    assign ap_idle          = ap_idle_q;
    assign ap_ready         = ap_ready_q;
    assign ap_done          = ap_done_q;
    assign ch_start         = ch_start_q;
    assign ch_abort         = ch_abort_q;
    assign status_timeout   = status_timeout_q;
    assign status_done_mask = status_done_mask_q;
    assign run_cycles       = run_cycles_q;

endmodule

// File: tb/tb_basic_axis_ctrl_chain.sv
module tb_basic_axis_ctrl_chain;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [31:0] mode;
    logic [31:0] timeout_cycles;
    logic [3:0]  ch_start;
    logic [3:0]  ch_abort;
    logic [3:0]  ch_done;
    logic        status_timeout;
    logic [3:0]  status_done_mask;
    logic [31:0] run_cycles;

    int total = 0;
    int bad   = 0;

    // Per-run channel schedule: RUN-cycle index (0 = first RUN cycle) of each ch_done, -1 = never.
    int done_at [4];

    // Observations captured by run_once.
    logic [3:0]  obs_ch_start, obs_abort, obs_abort_next, obs_dmask, obs_dmask_end;
    logic        obs_ready, obs_idle, obs_to, obs_to_end, obs_idle_end, obs_done_end;
    logic [31:0] obs_cycles, obs_cycles_end;
    int          obs_k, obs_ready_pulses, obs_done_cycles;
    bit          obs_reaccept;

    always #5 ap_clk = ~ap_clk;

    basic_axis_ctrl_chain #(
        .C_NUM_CHANNELS (4),
        .C_CHAIN_MODE   (1),
        .C_CNT_WIDTH    (32)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_continue      (ap_continue),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .ap_done          (ap_done),
        .mode             (mode),
        .timeout_cycles   (timeout_cycles),
        .ch_start         (ch_start),
        .ch_abort         (ch_abort),
        .ch_done          (ch_done),
        .status_timeout   (status_timeout),
        .status_done_mask (status_done_mask),
        .run_cycles       (run_cycles)
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Drives one complete run from IDLE and records what the DUT showed. Disabled channels get
    // random ch_done noise and already-finished channels get random repeat pulses.
    task automatic run_once(input logic [31:0] md, input logic [31:0] tmo, input int cont_delay,
                            input bit hold_start);
        logic [3:0] m, cd, seen;
        m = md[3:0];
        mode = md;
        timeout_cycles = tmo;
        ap_start = 1'b1;
        ap_continue = 1'b0;
        ch_done = '0;
        step();
        obs_ch_start = ch_start;
        obs_ready = ap_ready;
        obs_idle = ap_idle;
        obs_ready_pulses = ap_ready ? 1 : 0;
        obs_k = -1;
        obs_reaccept = 0;
        obs_done_cycles = 0;
        obs_abort_next = '0;
        if (!hold_start) ap_start = 1'b0;
        seen = '0;
        for (int k = 0; k < 300; k++) begin
            cd = '0;
            for (int i = 0; i < 4; i++) if (done_at[i] == k) cd[i] = 1'b1;
            cd = cd | (4'($urandom) & ~m) | (4'($urandom) & seen);
            seen = seen | (cd & m);
            ch_done = cd;
            step();
            if (ap_ready) obs_ready_pulses++;
            if (ap_done) begin
                obs_k = k;
                obs_abort = ch_abort;
                obs_to = status_timeout;
                obs_dmask = status_done_mask;
                obs_cycles = run_cycles;
                break;
            end
        end
        if (obs_k >= 0) begin
            obs_done_cycles = 1;
            for (int c = 0; c <= cont_delay; c++) begin
                ap_continue = (c == cont_delay);
                ch_done = 4'($urandom);
                step();
                if (c == 0) obs_abort_next = ch_abort;
                if (ap_ready) obs_reaccept = 1;
                if (ap_done) obs_done_cycles++;
            end
        end
        obs_idle_end = ap_idle;
        obs_done_end = ap_done;
        obs_to_end = status_timeout;
        obs_dmask_end = status_done_mask;
        obs_cycles_end = run_cycles;
        ap_continue = 1'b0;
        ch_done = '0;
    endtask

    task automatic test_reset();
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL reset ap_idle got %b want 1", ap_idle); end
        total++; if ({ap_ready, ap_done, status_timeout} !== 3'b000) begin bad++; $display("FAIL reset flags got %b want 000", {ap_ready, ap_done, status_timeout}); end
        total++; if ({ch_start, ch_abort, status_done_mask} !== 12'h000) begin bad++; $display("FAIL reset vectors got %h want 000", {ch_start, ch_abort, status_done_mask}); end
        total++; if (run_cycles !== 32'd0) begin bad++; $display("FAIL reset run_cycles got %0d want 0", run_cycles); end
    endtask

    task automatic test_all_channels();
        done_at = '{3, 7, 5, 10};
        run_once({$urandom_range(32'h0fff_ffff), 4'hF}, 32'd0, 0, 1'b0);
        total++; if (obs_ch_start !== 4'hF) begin bad++; $display("FAIL all ch_start got %h want f", obs_ch_start); end
        total++; if (obs_ready !== 1'b1 || obs_idle !== 1'b0) begin bad++; $display("FAIL all ready/idle got %b%b want 10", obs_ready, obs_idle); end
        total++; if (obs_ready_pulses !== 1) begin bad++; $display("FAIL all ready_pulses got %0d want 1", obs_ready_pulses); end
        total++; if (obs_k !== 10) begin bad++; $display("FAIL all done_latency got %0d want 10", obs_k); end
        total++; if (obs_dmask !== 4'hF) begin bad++; $display("FAIL all done_mask got %h want f", obs_dmask); end
        total++; if (obs_cycles !== 32'd11) begin bad++; $display("FAIL all run_cycles got %0d want 11", obs_cycles); end
        total++; if (obs_to !== 1'b0 || obs_abort !== 4'h0) begin bad++; $display("FAIL all to/abort got %b/%h want 0/0", obs_to, obs_abort); end
        total++; if (obs_done_cycles !== 1 || obs_idle_end !== 1'b1) begin bad++; $display("FAIL all done_len/idle got %0d/%b want 1/1", obs_done_cycles, obs_idle_end); end
    endtask

    task automatic test_masked();
        done_at = '{4, 1, 6, -1};
        run_once(32'h0000_0005, 32'd0, 1, 1'b0);
        total++; if (obs_ch_start !== 4'h5) begin bad++; $display("FAIL masked ch_start got %h want 5", obs_ch_start); end
        total++; if (obs_k !== 6) begin bad++; $display("FAIL masked done_latency got %0d want 6", obs_k); end
        total++; if (obs_dmask !== 4'h5 || obs_cycles !== 32'd7) begin bad++; $display("FAIL masked mask/cycles got %h/%0d want 5/7", obs_dmask, obs_cycles); end
    endtask

    task automatic test_timeout();
        done_at = '{2, -1, -1, -1};
        run_once(32'h0000_0003, 32'd20, 0, 1'b0);
        total++; if (obs_k !== 19) begin bad++; $display("FAIL timeout latency got %0d want 19", obs_k); end
        total++; if (obs_abort !== 4'h2) begin bad++; $display("FAIL timeout ch_abort got %h want 2", obs_abort); end
        total++; if (obs_abort_next !== 4'h0) begin bad++; $display("FAIL timeout abort_len got %h want 0", obs_abort_next); end
        total++; if (obs_to !== 1'b1 || obs_dmask !== 4'h1) begin bad++; $display("FAIL timeout status got %b/%h want 1/1", obs_to, obs_dmask); end
        total++; if (obs_cycles !== 32'd20) begin bad++; $display("FAIL timeout run_cycles got %0d want 20", obs_cycles); end
        total++; if (obs_to_end !== 1'b1 || obs_cycles_end !== 32'd20) begin bad++; $display("FAIL timeout hold got %b/%0d want 1/20", obs_to_end, obs_cycles_end); end
    endtask

    task automatic test_chain_hold();
        done_at = '{0, 1, 2, 3};
        run_once(32'h0000_000F, 32'd0, 4, 1'b1);
        total++; if (obs_k !== 3) begin bad++; $display("FAIL chain done_latency got %0d want 3", obs_k); end
        total++; if (obs_done_cycles !== 5) begin bad++; $display("FAIL chain done_len got %0d want 5", obs_done_cycles); end
        total++; if (obs_reaccept !== 1'b0 || obs_ready_pulses !== 1) begin bad++; $display("FAIL chain reaccept got %b/%0d want 0/1", obs_reaccept, obs_ready_pulses); end
        total++; if (obs_idle_end !== 1'b1 || obs_done_end !== 1'b0) begin bad++; $display("FAIL chain after_cont got %b%b want 10", obs_idle_end, obs_done_end); end
        // Start still held: accepted on the first IDLE cycle.
        step();
        total++; if ({ap_ready, ap_idle, ch_start} !== 6'b10_1111) begin bad++; $display("FAIL chain restart got %b want 101111", {ap_ready, ap_idle, ch_start}); end
        ap_start = 1'b0;
        ch_done = 4'hF;
        step();
        ch_done = '0;
        total++; if (ap_done !== 1'b1 || run_cycles !== 32'd1) begin bad++; $display("FAIL chain run2 got %b/%0d want 1/1", ap_done, run_cycles); end
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        total++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin bad++; $display("FAIL chain run2_end got %b%b want 10", ap_idle, ap_done); end
    endtask

    task automatic test_zero_mask();
        done_at = '{-1, -1, -1, -1};
        run_once(32'hABCD_0000, 32'd0, 0, 1'b0);
        total++; if (obs_ch_start !== 4'h0 || obs_ready !== 1'b1) begin bad++; $display("FAIL zero ch_start/ready got %h/%b want 0/1", obs_ch_start, obs_ready); end
        total++; if (obs_k !== 0 || obs_cycles !== 32'd1) begin bad++; $display("FAIL zero latency got %0d/%0d want 0/1", obs_k, obs_cycles); end
        total++; if (obs_dmask !== 4'h0 || obs_to !== 1'b0) begin bad++; $display("FAIL zero status got %h/%b want 0/0", obs_dmask, obs_to); end
    endtask

    task automatic test_done_timeout_tie();
        done_at = '{2, 7, -1, -1};
        run_once(32'h0000_0003, 32'd8, 0, 1'b0);
        total++; if (obs_k !== 7) begin bad++; $display("FAIL tie latency got %0d want 7", obs_k); end
        total++; if (obs_to !== 1'b0 || obs_abort !== 4'h0) begin bad++; $display("FAIL tie to/abort got %b/%h want 0/0", obs_to, obs_abort); end
        total++; if (obs_dmask !== 4'h3 || obs_cycles !== 32'd8) begin bad++; $display("FAIL tie mask/cycles got %h/%0d want 3/8", obs_dmask, obs_cycles); end
    endtask

    task automatic test_random();
        logic [31:0] md, tmo;
        logic [3:0]  m, cov, dm, ab;
        int          cont, ck, tk, ek;
        bit          any_never, exp_to;
        for (int r = 0; r < 10; r++) begin
            md = $urandom;
            m = md[3:0];
            any_never = 0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) begin
                    done_at[i] = -1;
                    any_never = 1;
                end else begin
                    done_at[i] = $urandom_range(15);
                end
            end
            tmo = any_never ? $urandom_range(20, 1) : $urandom_range(20);
            cont = $urandom_range(3);
            // Reference: earliest RUN cycle covering the mask vs. RUN cycle tmo-1.
            ck = -1;
            for (int k = 0; k < 16 && ck < 0; k++) begin
                cov = '0;
                for (int i = 0; i < 4; i++)
                    if (m[i] && done_at[i] >= 0 && done_at[i] <= k) cov[i] = 1'b1;
                if (cov == m) ck = k;
            end
            tk = (tmo != 0) ? int'(tmo) - 1 : -1;
            if (ck >= 0 && (tk < 0 || ck <= tk)) begin
                ek = ck; exp_to = 0; dm = m; ab = '0;
            end else begin
                ek = tk; exp_to = 1;
                dm = '0;
                for (int i = 0; i < 4; i++)
                    if (m[i] && done_at[i] >= 0 && done_at[i] <= tk) dm[i] = 1'b1;
                ab = m & ~dm;
            end
            run_once(md, tmo, cont, 1'b0);
            total++; if (obs_ch_start !== m) begin bad++; $display("FAIL rand%0d ch_start got %h want %h", r, obs_ch_start, m); end
            total++; if (obs_k !== ek) begin bad++; $display("FAIL rand%0d latency got %0d want %0d", r, obs_k, ek); end
            total++; if (obs_cycles !== 32'(ek + 1)) begin bad++; $display("FAIL rand%0d run_cycles got %0d want %0d", r, obs_cycles, ek + 1); end
            total++; if (obs_to !== exp_to || obs_abort !== ab) begin bad++; $display("FAIL rand%0d to/abort got %b/%h want %b/%h", r, obs_to, obs_abort, exp_to, ab); end
            total++; if (obs_dmask !== dm || obs_dmask_end !== dm) begin bad++; $display("FAIL rand%0d done_mask got %h/%h want %h", r, obs_dmask, obs_dmask_end, dm); end
            total++; if (obs_done_cycles !== cont + 1 || obs_idle_end !== 1'b1) begin bad++; $display("FAIL rand%0d done_len/idle got %0d/%b want %0d/1", r, obs_done_cycles, obs_idle_end, cont + 1); end
            total++; if (obs_abort_next !== 4'h0) begin bad++; $display("FAIL rand%0d abort_len got %h want 0", r, obs_abort_next); end
        end
    endtask

    task automatic test_reset_midrun();
        mode = 32'h0000_000F;
        timeout_cycles = 32'd0;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        ch_done = 4'h1;
        step();
        ch_done = '0;
        step();
        #2;
        ap_rst_n = 1'b0;
        #1;
        total++; if ({ap_idle, ap_ready, ap_done, status_timeout} !== 4'b1000) begin bad++; $display("FAIL midrst flags got %b want 1000", {ap_idle, ap_ready, ap_done, status_timeout}); end
        total++; if ({ch_start, ch_abort, status_done_mask} !== 12'h000 || run_cycles !== 32'd0) begin bad++; $display("FAIL midrst values got %h/%0d want 000/0", {ch_start, ch_abort, status_done_mask}, run_cycles); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL midrst idle_after got %b want 1", ap_idle); end
        done_at = '{2, -1, -1, -1};
        run_once(32'h0000_0001, 32'd0, 0, 1'b0);
        total++; if (obs_k !== 2 || obs_dmask !== 4'h1 || obs_cycles !== 32'd3) begin bad++; $display("FAIL midrst rerun got %0d/%h/%0d want 2/1/3", obs_k, obs_dmask, obs_cycles); end
    endtask

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        ap_continue = 1'b0;
        mode = '0;
        timeout_cycles = '0;
        ch_done = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        test_reset();
        test_all_channels();
        test_masked();
        test_timeout();
        test_chain_hold();
        test_zero_mask();
        test_done_timeout_tie();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
